hybrid_noc_router_lookup_cfg: RTL
=================================

Name: hybrid_noc_router_lookup_cfg

Overview:
Input-port lookup stage for the hybrid NoC router with distributed routing. It is the successor of the fixed-table lookup.
- Routing table is runtime-writable through a config port and carries a per-entry valid bit.
- LOCAL_LINKS local links are selected by a header field.
- Two-entry skid buffer gives registered in_ready and full throughput.
- Discarded packets are counted with a saturating counter.
Sits between the input FIFO and the switch arbiters of each router input port.

Parameters:
FLIT_WIDTH, 32, flit width
PORTS, 5, number of router output ports
TABLE_WIDTH, 3, port-index width of a table entry
DESTS, 9, number of routing table entries
DEST_WIDTH, 10, header destination field width
DEST_POS, 0, LSB of destination field in header
LOCAL, 0, port index of first local link
LOCAL_LINKS, 2, number of local links (1..4); requires LOCAL+LOCAL_LINKS<=PORTS
LINK_POS, 23, LSB of link-select field in header (width LSEL_W=max(1,clog2(LOCAL_LINKS)))
ROUTES_INIT, 0, reset contents of table, DESTS*(TABLE_WIDTH+1) bits, entry {valid,port}
CNT_WIDTH, 16, discard counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_flit  in  FLIT_WIDTH  input flit
in_valid  in  1  input valid
in_last  in  1  last flit of packet
in_ready  out  1  input ready (registered)
out_flit  out  FLIT_WIDTH  output flit
out_valid  out  PORTS  one-hot output-port request
out_last  out  1  last flit
out_ready  in  PORTS  per-port ready
cfg_we  in  1  table write strobe
cfg_addr  in  DEST_WIDTH  table entry index
cfg_data  in  TABLE_WIDTH+1  {valid,port}
discard_cnt  out  CNT_WIDTH  packets discarded
discard_clr  in  1  clear discard_cnt

Behaviour:
- Reset values: table=ROUTES_INIT; buffer empty; out_valid=0; in_ready=1 in first cycle after reset; discard_cnt=0; header state=1; discarding=0. out_flit/out_last are don't-care while out_valid=0.
- Input transfer: in_valid & in_ready. The first flit after reset or after a transferred last flit is a header.
- Header lookup is combinational on in_flit:
  - discard if dest>=DESTS or entry valid bit=0.
  - Otherwise port=entry.port; if port==LOCAL, add sel=in_flit[LINK_POS+:LSEL_W]; sel>=LOCAL_LINKS maps to 0.
  - Request vector = 1<<(port+sel) (sel=0 for non-local). Latched once per packet, held for all flits of that packet.
- Discard:
  - Discarding packets are accepted whenever in_valid=1, regardless of buffer state (in_ready forced 1 while discarding; header discard also acks immediately).
  - Discarded flits never enter the buffer.
  - discard_cnt increments once per discarded header, saturates at all-ones.
  - discard_clr has priority over increment in the same cycle.
- Skid buffer: 2 entries of {flit,last,port vector}.
  - in_ready = not full (registered), except in discard mode.
  - Latency in->out = 1 cycle.
  - Output head: out_valid = port vector when non-empty, else 0; pop when |(out_valid&out_ready).
  - Simultaneous push and pop keeps occupancy; push into a full buffer never occurs.
  - Sustained 1 flit/cycle when out_ready is held high.
- Table write: cfg_we writes entry cfg_addr at the clock edge; writes with cfg_addr>=DESTS are ignored.
  - A lookup in the same cycle sees the old entry (read-before-write).
  - A write never affects a packet whose header has already been looked up.
- Single-flit packet (header with in_last): lookup and last handled in the same transfer; the next flit is a header.
- rst mid-packet: abandons the packet. The buffer empties and the next flit is treated as a header. The table reloads ROUTES_INIT.

Decomposition:
- Package hybrid_noc_pkg: route entry typedef {valid,port}, LSEL_W function, clog2 helper.
- Sub-module hybrid_noc_skid_buffer: 2-entry buffer, parametrised data width, registered ready.
- Table, lookup and discard FSM stay in the top module.

Test Plan:
- ROUTES_INIT: dest 3 -> port 2. 3-flit packet dest 3, out_ready=all ones -> out_valid=5'b00100 one cycle after each flit, back-to-back, out_last on flit 3.
- Header dest 4 with entry {1,LOCAL=0}, in_flit[23]=1, LOCAL_LINKS=2 -> out_valid=5'b00010. Link field beyond range with LOCAL_LINKS=1 -> 5'b00001.
- Header dest 12 (>=DESTS), 4 flits -> all acked at 1/cycle, out_valid stays 0, discard_cnt=1. Repeat with dest 5 entry valid=0 -> discard_cnt=2. discard_clr together with a new discard -> discard_cnt=0.
- Hold out_ready=0 after 2 flits -> in_ready=0 the next cycle, no flit lost. Release -> order preserved, throughput 1/cycle.
- cfg_we dest 3 -> {1,4} in the header lookup cycle for dest 3 -> that packet still goes to port 2. Next packet goes to port 4 (5'b10000).
- rst asserted after flit 2 of a 4-flit packet -> out_valid=0, discard_cnt=0. First flit after reset is routed as a header.

Source files
------------

// File: rtl/hybrid_noc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hybrid_noc_pkg                                                             |
// | Shared types and elaboration helpers for the hybrid NoC router lookup.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package hybrid_noc_pkg;

    // Route entry at the default table geometry ({valid, port}).
    localparam int c_ROUTE_PORT_W = 3;

    typedef struct packed {
        logic                      valid;
        logic [c_ROUTE_PORT_W-1:0] port;
    } route_entry_t;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Link-select field is at least one bit wide even for a single local link.
    function automatic int lsel_w(input int links);
        return (links > 1) ? clog2(links) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hybrid_noc_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hybrid_noc_skid_buffer                                                     |
// | Two-entry buffer with registered ready; sustains one transfer per cycle.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hybrid_noc_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic             r_ready;
    logic [1:0]       r_count;
    logic [1:0]       w_count_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & r_ready;
    assign w_pop  = i_pop & (r_count != 2'd0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push & ~w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (w_pop & ~w_push) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // Ready is derived from next occupancy so it is a pure flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_ready = r_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/hybrid_noc_router_lookup_cfg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hybrid_noc_router_lookup_cfg                                               |
// | Input-port route lookup with writable table, local-link select, discard.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hybrid_noc_router_lookup_cfg
    import hybrid_noc_pkg::*;
#(
    parameter int FLIT_WIDTH  = 32,
    parameter int PORTS       = 5,
    parameter int TABLE_WIDTH = 3,
    parameter int DESTS       = 9,
    parameter int DEST_WIDTH  = 10,
    parameter int DEST_POS    = 0,
    parameter int LOCAL       = 0,
    parameter int LOCAL_LINKS = 2,
    parameter int LINK_POS    = 23,
    parameter logic [DESTS*(TABLE_WIDTH+1)-1:0] ROUTES_INIT = '0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_WIDTH-1:0]  in_flit,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [FLIT_WIDTH-1:0]  out_flit,
    output logic [PORTS-1:0]       out_valid,
    output logic                   out_last,
    input  logic [PORTS-1:0]       out_ready,
    input  logic                   cfg_we,
    input  logic [DEST_WIDTH-1:0]  cfg_addr,
    input  logic [TABLE_WIDTH:0]   cfg_data,
    output logic [CNT_WIDTH-1:0]   discard_cnt,
    input  logic                   discard_clr
);

    localparam int c_ENTRY_W = TABLE_WIDTH + 1;
    localparam int c_LSEL_W  = lsel_w(LOCAL_LINKS);
    localparam int c_IDX_W   = (DESTS > 1) ? clog2(DESTS) : 1;
    localparam int c_SUM_W   = TABLE_WIDTH + 3;
    localparam int c_BUF_W   = FLIT_WIDTH + 1 + PORTS;
    localparam int c_DLIM_W  = DEST_WIDTH + 1;
    localparam logic [DEST_WIDTH:0]    c_DEST_LIMIT = c_DLIM_W'(DESTS);
    localparam logic [TABLE_WIDTH-1:0] c_LOCAL_PORT = TABLE_WIDTH'(LOCAL);

    localparam logic [1:0] c_S_HEAD = 2'd0;
    localparam logic [1:0] c_S_BODY = 2'd1;
    localparam logic [1:0] c_S_DROP = 2'd2;

    typedef struct packed {
        logic                   valid;
        logic [TABLE_WIDTH-1:0] port;
    } entry_t;

    entry_t                r_table [DESTS];
    logic [1:0]            r_state;
    logic [PORTS-1:0]      r_req;
    logic [CNT_WIDTH-1:0]  r_discard_cnt;

    logic [DEST_WIDTH-1:0] w_dest;
    logic                  w_dest_ok;
    entry_t                w_entry;
    logic                  w_hdr_drop;
    logic [c_LSEL_W-1:0]   w_sel_raw;
    logic [c_SUM_W-1:0]    w_sel;
    logic [c_SUM_W-1:0]    w_idx;
    logic [PORTS-1:0]      w_req;
    logic                  w_is_head;
    logic                  w_xfer;
    logic                  w_push;
    logic [PORTS-1:0]      w_push_vec;
    logic                  w_buf_ready;
    logic                  w_buf_valid;
    logic [c_BUF_W-1:0]    w_head_data;
    logic [PORTS-1:0]      w_head_vec;
    logic                  w_pop;

    // Combinational lookup; the table read sees the pre-write entry.
    always_comb begin
        w_dest     = in_flit[DEST_POS +: DEST_WIDTH];
        w_dest_ok  = ({1'b0, w_dest} < c_DEST_LIMIT);
        w_entry    = w_dest_ok ? r_table[w_dest[c_IDX_W-1:0]] : '0;
        w_hdr_drop = ~w_dest_ok | ~w_entry.valid;
        w_sel_raw  = in_flit[LINK_POS +: c_LSEL_W];
        w_sel      = '0;
        if ((w_entry.port == c_LOCAL_PORT) &&
            (c_SUM_W'(w_sel_raw) < c_SUM_W'(LOCAL_LINKS))) begin
            w_sel = c_SUM_W'(w_sel_raw);
        end
        w_idx = c_SUM_W'(w_entry.port) + w_sel;
        for (int p = 0; p < PORTS; p++) begin
            w_req[p] = (w_idx == c_SUM_W'(p));
        end
    end

    assign w_is_head  = (r_state == c_S_HEAD);
    assign in_ready   = (r_state == c_S_DROP) | (w_is_head & w_hdr_drop) | w_buf_ready;
    assign w_xfer     = in_valid & in_ready;
    assign w_push     = w_xfer & ((r_state == c_S_BODY) | (w_is_head & ~w_hdr_drop));
    assign w_push_vec = w_is_head ? w_req : r_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_S_HEAD;
            r_req         <= '0;
            r_discard_cnt <= '0;
            for (int i = 0; i < DESTS; i++) begin
                r_table[i] <= ROUTES_INIT[i*c_ENTRY_W +: c_ENTRY_W];
            end
        end else begin
            if (w_xfer) begin
                if (w_is_head) begin
                    r_req   <= w_req;
                    r_state <= in_last ? c_S_HEAD : (w_hdr_drop ? c_S_DROP : c_S_BODY);
                end else if (in_last) begin
                    r_state <= c_S_HEAD;
                end
            end
            if (discard_clr) begin
                r_discard_cnt <= '0;
            end else if (w_xfer & w_is_head & w_hdr_drop & ~(&r_discard_cnt)) begin
                r_discard_cnt <= r_discard_cnt + CNT_WIDTH'(1);
            end
            if (cfg_we && ({1'b0, cfg_addr} < c_DEST_LIMIT)) begin
                r_table[cfg_addr[c_IDX_W-1:0]] <= cfg_data;
            end
        end
    end

    hybrid_noc_skid_buffer #(
        .WIDTH (c_BUF_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({in_flit, in_last, w_push_vec}),
        .o_ready (w_buf_ready),
        .i_pop   (w_pop),
        .o_valid (w_buf_valid),
        .o_data  (w_head_data)
    );

    assign {out_flit, out_last, w_head_vec} = w_head_data;
    assign out_valid   = w_buf_valid ? w_head_vec : '0;
    assign w_pop       = |(out_valid & out_ready);
    assign discard_cnt = r_discard_cnt;

endmodule
`default_nettype wire
